// File: rtl/wave_shaper_pipe.sv
// Phase-to-amplitude shaper: triangle, sawtooth, square and quarter-wave cosine.
// Two-stage pipeline. Wave and duty selections are shadowed and applied at phase wrap or on accept.
module wave_shaper_pipe #(
    parameter int unsigned PHASE_W  = 8,
    parameter int unsigned AMP_W    = 10,
    parameter int unsigned LUT_AW   = 6,
    parameter int unsigned SEL_SYNC = 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    input  logic               phase_vld,
    input  logic [PHASE_W-1:0] phase_in,
    input  logic [1:0]         sel,
    input  logic [PHASE_W-1:0] duty,
    output logic [AMP_W-1:0]   amplitude,
    output logic               out_vld,
    output logic [1:0]         sel_act,
    output logic               chg_pend
);

    localparam int unsigned N  = 1 << LUT_AW;
    localparam int unsigned TW = AMP_W - 1;
    localparam logic [AMP_W-1:0]   MID      = {1'b1, {(AMP_W-1){1'b0}}};
    localparam logic [PHASE_W-1:0] DUTY_RST = {1'b1, {(PHASE_W-1){1'b0}}};

    typedef enum logic [1:0] {
        WAVE_TRI = 2'b00,
        WAVE_SAW = 2'b01,
        WAVE_SQR = 2'b10,
        WAVE_COS = 2'b11
    } wave_e;

    // Quarter-wave table round((M-1)*cos(pi/2*k/N)), evaluated at elaboration
    // with a fixed-point (2^30) Taylor series so no real arithmetic reaches synthesis.
    function automatic logic [(N+1)*TW-1:0] build_lut();
        logic [(N+1)*TW-1:0] lut;
        longint one, pi_fx, x, x2, term, sum, val;
        lut   = '0;
        one   = longint'(1) << 30;
        pi_fx = 64'sd3373259426;
        for (int unsigned k = 0; k <= N; k++) begin
            x    = (pi_fx * longint'(k)) / longint'(2 * N);
            x2   = (x * x) / one;
            term = one;
            sum  = one;
            for (int unsigned n = 1; n <= 12; n++) begin
                term = -((term * x2) / one) / longint'((2 * n - 1) * (2 * n));
                sum  = sum + term;
            end
            if (sum < 0) sum = 0;
            val = (sum * ((longint'(1) << TW) - 1) + one / 2) / one;
            lut[k*TW +: TW] = TW'(val);
        end
        return lut;
    endfunction

    localparam logic [(N+1)*TW-1:0] LUT = build_lut();

    logic [PHASE_W-1:0] r_last_ph;
    logic [1:0]         r_sel_act;
    logic [PHASE_W-1:0] r_duty_s;
    logic               r_v1;
    wave_e              r_mode;
    logic [1:0]         r_q;
    logic [LUT_AW-1:0]  r_idx;
    logic [AMP_W-1:0]   r_res;
    logic [AMP_W-1:0]   r_amp;
    logic               r_out_vld;

    logic               w_acc;
    logic               w_wrap;
    logic               w_upd;
    logic [1:0]         w_sel;
    logic [PHASE_W-1:0] w_duty;
    logic [PHASE_W-2:0] w_tri;
    logic [AMP_W-1:0]   w_tri_amp;
    logic [AMP_W-1:0]   w_saw_amp;
    logic [AMP_W-1:0]   w_res;
    logic [LUT_AW:0]    w_rev_idx;
    logic [TW-1:0]      w_t_dir;
    logic [TW-1:0]      w_t_rev;
    logic [AMP_W-1:0]   w_cos;

    assign w_acc  = en & phase_vld;
    assign w_wrap = w_acc & (phase_in < r_last_ph);
    assign w_upd  = (SEL_SYNC != 0) ? w_wrap : w_acc;
    // The accepted sample already uses the values being latched into the shadow.
    assign w_sel  = w_upd ? sel  : r_sel_act;
    assign w_duty = w_upd ? duty : r_duty_s;
    assign w_tri  = phase_in[PHASE_W-1] ? ~phase_in[PHASE_W-2:0] : phase_in[PHASE_W-2:0];

    if (AMP_W >= PHASE_W - 1) begin : g_tri_pad
        assign w_tri_amp = AMP_W'(w_tri) << (AMP_W - PHASE_W + 1);
    end else begin : g_tri_trunc
        assign w_tri_amp = AMP_W'(w_tri >> (PHASE_W - 1 - AMP_W));
    end

    if (AMP_W >= PHASE_W) begin : g_saw_pad
        assign w_saw_amp = AMP_W'(phase_in) << (AMP_W - PHASE_W);
    end else begin : g_saw_trunc
        assign w_saw_amp = AMP_W'(phase_in >> (PHASE_W - AMP_W));
    end

    always_comb begin
        w_res = '0;
        case (wave_e'(w_sel))
            WAVE_TRI: w_res = w_tri_amp;
            WAVE_SAW: w_res = w_saw_amp;
            WAVE_SQR: w_res = (phase_in < w_duty) ? {AMP_W{1'b1}} : {AMP_W{1'b0}};
            default:  w_res = '0;
        endcase
    end

    assign w_rev_idx = (LUT_AW+1)'(N) - {1'b0, r_idx};
    assign w_t_dir   = LUT[r_idx*TW +: TW];
    assign w_t_rev   = LUT[w_rev_idx*TW +: TW];

    always_comb begin
        w_cos = MID;
        case (r_q)
            2'd0:    w_cos = MID + AMP_W'(w_t_dir);
            2'd1:    w_cos = MID - AMP_W'(w_t_rev);
            2'd2:    w_cos = MID - AMP_W'(w_t_dir);
            default: w_cos = MID + AMP_W'(w_t_rev);
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_last_ph <= '1;
            r_sel_act <= '0;
            r_duty_s  <= DUTY_RST;
            r_v1      <= 1'b0;
            r_mode    <= WAVE_TRI;
            r_q       <= '0;
            r_idx     <= '0;
            r_res     <= '0;
            r_amp     <= '0;
            r_out_vld <= 1'b0;
        end else if (!en) begin
            r_last_ph <= '1;
            r_sel_act <= sel;
            r_duty_s  <= duty;
            r_v1      <= 1'b0;
            r_amp     <= '0;
            r_out_vld <= 1'b0;
        end else begin
            r_v1      <= w_acc;
            r_out_vld <= r_v1;
            if (w_acc) begin
                r_last_ph <= phase_in;
                r_mode    <= wave_e'(w_sel);
                r_q       <= phase_in[PHASE_W-1 -: 2];
                r_idx     <= phase_in[PHASE_W-3 -: LUT_AW];
                r_res     <= w_res;
            end
            if (w_upd) begin
                r_sel_act <= sel;
                r_duty_s  <= duty;
            end
            if (r_v1) r_amp <= (r_mode == WAVE_COS) ? w_cos : r_res;
        end
    end

    assign amplitude = r_amp;
    assign out_vld   = r_out_vld;
    assign sel_act   = r_sel_act;
    assign chg_pend  = (sel != r_sel_act) || (duty != r_duty_s);

endmodule

// File: tb/tb_wave_shaper_pipe.sv
// Directed bench for wave_shaper_pipe: a due-cycle scoreboard checks every output slot.
module tb_wave_shaper_pipe;

    logic       clk = 1'b0;
    logic       rstn, en, phase_vld;
    logic [7:0] phase_in, duty;
    logic [1:0] sel;
    logic [9:0] amplitude;
    logic       out_vld;
    logic [1:0] sel_act;
    logic       chg_pend;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    typedef struct {
        int due;
        int exp;
        int ph;
    } ent_t;
    ent_t sb[$];

    wave_shaper_pipe #(
        .PHASE_W (8),
        .AMP_W   (10),
        .LUT_AW  (6),
        .SEL_SYNC(1)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .phase_vld(phase_vld),
        .phase_in (phase_in),
        .sel      (sel),
        .duty     (duty),
        .amplitude(amplitude),
        .out_vld  (out_vld),
        .sel_act  (sel_act),
        .chg_pend (chg_pend)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // Every output slot: either a scheduled sample is due, or out_vld must be low.
    always @(negedge clk) begin
        ent_t e;
        if (sb.size() > 0 && sb[0].due == edge_n) begin
            e = sb.pop_front();
            chk($sformatf("vld_ph%0d", e.ph), int'(out_vld), 1);
            if (e.exp >= 0) chk($sformatf("amp_ph%0d", e.ph), int'(amplitude), e.exp);
        end else begin
            chk("idle_vld", int'(out_vld), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int ph, input logic [1:0] s, input int exp);
        en        = 1'b1;
        phase_vld = v;
        phase_in  = ph[7:0];
        sel       = s;
        if (v) sb.push_back('{edge_n + 2, exp, ph});
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            en        = 1'b1;
            phase_vld = 1'b0;
            tick();
        end
    endtask

    // One cycle with en low: anything not yet on the output is discarded.
    task automatic flush(input logic [1:0] s);
        en        = 1'b0;
        phase_vld = 1'b0;
        sel       = s;
        while (sb.size() > 0 && sb[$].due > edge_n) void'(sb.pop_back());
        tick();
        chk("flush_vld", int'(out_vld), 0);
        chk("flush_amp", int'(amplitude), 0);
    endtask

    initial begin
        rstn = 1'b1; en = 1'b0; phase_vld = 1'b0; phase_in = '0; sel = 2'b00; duty = 8'd128;
        #2 rstn = 1'b0;
        #1;
        chk("rst_amp", int'(amplitude), 0);
        chk("rst_vld", int'(out_vld), 0);
        chk("rst_sel_act", int'(sel_act), 0);
        chk("rst_pend_duty128", int'(chg_pend), 0);
        duty = 8'd5;
        #1 chk("rst_pend_duty5", int'(chg_pend), 1);
        duty = 8'd128;
        tick();
        tick();
        rstn = 1'b1;

        // cosine quadrant points
        drive(1, 0, 2'b11, 1023);
        drive(1, 64, 2'b11, 512);
        drive(1, 128, 2'b11, 1);
        drive(1, 192, 2'b11, 512);
        idle(3);

        // triangle, then sawtooth after an en pulse
        drive(1, 0, 2'b00, 0);
        drive(1, 127, 2'b00, 1016);
        drive(1, 128, 2'b00, 1016);
        drive(1, 255, 2'b00, 0);
        idle(3);
        flush(2'b01);
        drive(1, 255, 2'b01, 1020);
        idle(3);

        // square with duty 64, then duty 0
        duty = 8'd64;
        flush(2'b10);
        drive(1, 63, 2'b10, 1023);
        drive(1, 64, 2'b10, 0);
        drive(1, 0, 2'b10, 1023);
        idle(3);
        duty = 8'd0;
        flush(2'b10);
        drive(1, 0, 2'b10, 0);
        idle(3);

        // cosine ramp; square requested mid-way takes effect only at wrap
        duty = 8'd128;
        flush(2'b11);
        for (int p = 0; p < 256; p++) begin
            int e;
            e = (p == 32) ? 873 : (p == 100) ? 117 : (p == 200) ? 612 : (p == 255) ? 1023 : -1;
            drive(1, p, (p >= 100) ? 2'b10 : 2'b11, e);
            if (p == 100) chk("pend_after_req", int'(chg_pend), 1);
            if (p == 200) chk("sel_act_held", int'(sel_act), 3);
        end
        drive(1, 0, 2'b10, 1023);
        chk("sel_act_wrap", int'(sel_act), 2);
        chk("pend_cleared", int'(chg_pend), 0);
        idle(3);

        // valid gaps: accepts 3 cycles apart, amplitude holds between
        flush(2'b01);
        drive(1, 64, 2'b01, 256);
        drive(0, 0, 2'b01, -1);
        drive(0, 0, 2'b01, -1);
        chk("hold1_amp", int'(amplitude), 256);
        chk("hold1_vld", int'(out_vld), 0);
        drive(1, 128, 2'b01, 512);
        chk("hold2_amp", int'(amplitude), 256);
        idle(3);

        // asynchronous reset mid-stream
        flush(2'b11);
        drive(1, 0, 2'b11, 1023);
        drive(1, 64, 2'b11, 512);
        drive(1, 128, 2'b11, 1);
        chk("pre_rst_vld", int'(out_vld), 1);
        chk("pre_rst_sel_act", int'(sel_act), 3);
        rstn = 1'b0;
        #1;
        chk("mid_rst_amp", int'(amplitude), 0);
        chk("mid_rst_vld", int'(out_vld), 0);
        chk("mid_rst_sel_act", int'(sel_act), 0);
        sb.delete();
        tick();
        rstn = 1'b1;

        // en low with samples in flight
        drive(1, 0, 2'b11, 1023);
        drive(1, 64, 2'b11, 512);
        flush(2'b11);
        idle(4);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
